ram32x4_arbiter: RTL and testbench

Access controller for the 32x4 on-chip RAM, driving it as a single shared port. It grants one access per clock to either a write requester (switch/key entry path) or a read requester (address-scan display path), using round-robin priority. It also contains a clear engine that fills all 32 words with a constant. It sits between the board-level control logic and the RAM macro, and replaces direct wiring of switch and counter signals into the RAM.

---
 rtl/ram32x4_arbiter.sv | 126 ++++++++++++
 tb/tb_ram32x4_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram32x4_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram32x4_arbiter : round-robin single-port access controller for the 32x4  |
// |                   RAM (write/read requesters) with a full-memory clear.    |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
module ram32x4_arbiter #(
  parameter int unsigned       ADDR_W    = 5,
  parameter int unsigned       DATA_W    = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_start,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] c_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              prio_rd_q, prio_rd_d;   // 0: write wins a tie, 1: read wins
  logic              rd_valid_q, rd_valid_d;

  logic              w_grant_wr;
  logic              w_grant_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prio_rd_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prio_rd_q  <= prio_rd_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    w_grant_wr = wr_req && (!rd_req || !prio_rd_q);
    w_grant_rd = rd_req && (!wr_req ||  prio_rd_q);
  end

  // The RAM samples its inputs on the same edge that applies reset, so every
  // RAM-facing output is forced quiet while reset is high; this keeps an
  // aborted clear from writing one extra word.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prio_rd_d  = prio_rd_q;
    rd_valid_d = 1'b0;
    wr_gnt     = 1'b0;
    rd_gnt     = 1'b0;
    busy       = 1'b0;
    ram_wren   = 1'b0;
    ram_addr   = '0;
    ram_data   = '0;

    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end else if (w_grant_wr) begin
            wr_gnt    = 1'b1;
            ram_wren  = 1'b1;
            ram_addr  = wr_addr;
            ram_data  = wr_data;
            prio_rd_d = 1'b1;
          end else if (w_grant_rd) begin
            rd_gnt     = 1'b1;
            ram_addr   = rd_addr;
            rd_valid_d = 1'b1;
            prio_rd_d  = 1'b0;
          end
        end
        CLEAR: begin
          busy     = 1'b1;
          ram_wren = 1'b1;
          ram_addr = cnt_q;
          ram_data = CLEAR_VAL;
          if (cnt_q == c_last_addr) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_addr_one;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    rd_valid = rd_valid_q;
    rd_data  = rd_valid_q ? ram_q : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_ram32x4_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ram32x4_arbiter : self-checking bench with a behavioural RAM fixture.   |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
module tb_ram32x4_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_start;
  logic       wr_req;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_gnt;
  logic       rd_req;
  logic [4:0] rd_addr;
  logic       rd_gnt;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic       busy;
  logic [4:0] ram_addr;
  logic [3:0] ram_data;
  logic       ram_wren;
  logic [3:0] ram_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram32x4_arbiter #(.ADDR_W(5), .DATA_W(4), .CLEAR_VAL(4'h0)) dut (
    .clk(clk), .reset(reset), .clear_start(clear_start),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // RAM macro: registered address/data/wren, unregistered output
  logic [3:0] mem [32];
  logic [4:0] ram_addr_r;
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_addr_r <= ram_addr;
  end
  assign ram_q = mem[ram_addr_r];

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    clear_start = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic fill(input logic [3:0] v);
    for (int i = 0; i < 32; i++) begin
      wr_req = 1'b1; wr_addr = 5'(i); wr_data = v;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic run_clear;
    clear_start = 1'b1;
    next_cycle();
    clear_start = 1'b0;
    repeat (33) next_cycle();
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++; if (wr_gnt !== 1'b0)   begin errors++; $display("FAIL reset_wr_gnt: got %b expected 0", wr_gnt); end
    checks++; if (rd_gnt !== 1'b0)   begin errors++; $display("FAIL reset_rd_gnt: got %b expected 0", rd_gnt); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_ram_wren: got %b expected 0", ram_wren); end
    checks++; if (ram_addr !== 5'd0) begin errors++; $display("FAIL reset_ram_addr: got %0h expected 0", ram_addr); end
    checks++; if (ram_data !== 4'd0) begin errors++; $display("FAIL reset_ram_data: got %0h expected 0", ram_data); end
    next_cycle();
  endtask

  task automatic test_write_read;
    do_reset();
    wr_req = 1'b1; wr_addr = 5'd2; wr_data = 4'hA;
    @(negedge clk);
    checks++; if ({wr_gnt, ram_wren, ram_addr, ram_data} !== {1'b1, 1'b1, 5'd2, 4'hA})
      begin errors++; $display("FAIL wr_issue: got gnt=%b wren=%b addr=%0h data=%0h expected 1 1 2 a", wr_gnt, ram_wren, ram_addr, ram_data); end
    next_cycle();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 5'd2;
    @(negedge clk);
    checks++; if ({rd_gnt, ram_wren, ram_addr} !== {1'b1, 1'b0, 5'd2})
      begin errors++; $display("FAIL rd_issue: got gnt=%b wren=%b addr=%0h expected 1 0 2", rd_gnt, ram_wren, ram_addr); end
    next_cycle();
    rd_req = 1'b0;
    @(negedge clk);
    checks++; if ({rd_valid, rd_data} !== {1'b1, 4'hA})
      begin errors++; $display("FAIL rd_return: got valid=%b data=%0h expected 1 a", rd_valid, rd_data); end
    next_cycle();
  endtask

  task automatic test_contention;
    do_reset();
    wr_req = 1'b1; wr_addr = 5'd7; wr_data = 4'h1;
    rd_req = 1'b1; rd_addr = 5'd9;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if ({wr_gnt, rd_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
        begin errors++; $display("FAIL contention_grant[%0d]: got w=%b r=%b expected %s", k, wr_gnt, rd_gnt, (k % 2 == 0) ? "W" : "R"); end
      checks++; if (rd_valid !== ((k % 2 == 0) && k > 0))
        begin errors++; $display("FAIL contention_valid[%0d]: got %b expected %b", k, rd_valid, (k % 2 == 0) && k > 0); end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL contention_last_valid: got %b expected 1", rd_valid); end
    next_cycle();
  endtask

  task automatic test_clear;
    fill(4'hF);
    clear_start = 1'b1; rd_req = 1'b1; rd_addr = 5'd4;
    @(negedge clk);
    checks++; if ({wr_gnt, rd_gnt, ram_wren} !== 3'b000)
      begin errors++; $display("FAIL clear_start_no_grant: got w=%b r=%b wren=%b expected 0 0 0", wr_gnt, rd_gnt, ram_wren); end
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++; if ({busy, ram_wren, ram_addr, ram_data} !== {1'b1, 1'b1, 5'(i), 4'h0})
        begin errors++; $display("FAIL clear_step[%0d]: got busy=%b wren=%b addr=%0d data=%0h expected 1 1 %0d 0", i, busy, ram_wren, ram_addr, ram_data, i); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if ({busy, ram_wren} !== 2'b00) begin errors++; $display("FAIL clear_end: got busy=%b wren=%b expected 0 0", busy, ram_wren); end
    for (int i = 0; i <= 32; i++) begin
      rd_req = (i < 32); rd_addr = 5'(i % 32);
      @(negedge clk);
      if (i > 0) begin
        checks++; if ({rd_valid, rd_data} !== {1'b1, 4'h0})
          begin errors++; $display("FAIL clear_readback[%0d]: got valid=%b data=%0h expected 1 0", i - 1, rd_valid, rd_data); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_stall;
    int busy_cycles;
    logic granted;
    busy_cycles = 0;
    granted = 1'b0;
    clear_start = 1'b1;
    next_cycle();
    clear_start = 1'b0; rd_req = 1'b1; rd_addr = 5'd5;
    for (int n = 0; n < 40 && !granted; n++) begin
      @(negedge clk);
      if (busy) begin
        busy_cycles++;
        checks++; if (rd_gnt !== 1'b0) begin errors++; $display("FAIL stall_rd_gnt[%0d]: got %b expected 0", n, rd_gnt); end
      end else begin
        checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", rd_gnt); end
        granted = 1'b1;
      end
      next_cycle();
      clear_start = (n == 10);
    end
    clear_start = 1'b0; rd_req = 1'b0;
    checks++; if (busy_cycles !== 32) begin errors++; $display("FAIL stall_busy_len: got %0d expected 32", busy_cycles); end
    @(negedge clk);
    checks++; if ({rd_valid, rd_data} !== {1'b1, 4'h0})
      begin errors++; $display("FAIL stall_rd_data: got valid=%b data=%0h expected 1 0", rd_valid, rd_data); end
    next_cycle();
  endtask

  task automatic test_reset_mid_clear;
    logic found;
    found = 1'b0;
    fill(4'h3);
    clear_start = 1'b1;
    next_cycle();
    clear_start = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (busy && ram_addr == 5'd10) found = 1'b1;
      else next_cycle();
    end
    checks++; if (!found) begin errors++; $display("FAIL midclear_reach10: got 0 expected 1"); end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({busy, ram_wren} !== 2'b00) begin errors++; $display("FAIL midclear_abort: got busy=%b wren=%b expected 0 0", busy, ram_wren); end
    next_cycle();
    for (int i = 0; i <= 32; i++) begin
      rd_req = (i < 32); rd_addr = 5'(i % 32);
      @(negedge clk);
      if (i > 0) begin
        checks++; if ({rd_valid, rd_data} !== {1'b1, (i - 1 < 10) ? 4'h0 : 4'h3})
          begin errors++; $display("FAIL midclear_readback[%0d]: got valid=%b data=%0h expected 1 %0h", i - 1, rd_valid, rd_data, (i - 1 < 10) ? 4'h0 : 4'h3); end
      end
      next_cycle();
    end
    idle_inputs();
    clear_start = 1'b1;
    next_cycle();
    clear_start = 1'b0;
    @(negedge clk);
    checks++; if ({busy, ram_wren, ram_addr} !== {1'b1, 1'b1, 5'd0})
      begin errors++; $display("FAIL midclear_restart: got busy=%b wren=%b addr=%0d expected 1 1 0", busy, ram_wren, ram_addr); end
    repeat (33) next_cycle();
  endtask

  task automatic test_back_to_back;
    wr_req = 1'b1; wr_addr = 5'd31; wr_data = 4'h6;
    @(negedge clk);
    checks++; if (wr_gnt !== 1'b1) begin errors++; $display("FAIL raw_wr_gnt: got %b expected 1", wr_gnt); end
    next_cycle();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 5'd31;
    @(negedge clk);
    checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL raw_rd_gnt: got %b expected 1", rd_gnt); end
    next_cycle();
    rd_req = 1'b0;
    @(negedge clk);
    checks++; if ({rd_valid, rd_data} !== {1'b1, 4'h6})
      begin errors++; $display("FAIL raw_data: got valid=%b data=%0h expected 1 6", rd_valid, rd_data); end
    next_cycle();
  endtask

  // Reference: memory array, clear countdown and "who was served last".
  task automatic test_random;
    logic [3:0] ref_mem [32];
    int         clear_left;
    bit         last_was_write;
    bit         pend_valid;
    logic [3:0] pend_data;
    logic       e_wg, e_rg, e_busy, e_wren;
    logic [4:0] e_addr;
    logic [3:0] e_data;
    bit         n_valid;
    logic [3:0] n_data;
    run_clear();
    do_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = 4'h0;
    clear_left = 0;
    last_was_write = 1'b0;
    pend_valid = 1'b0;
    pend_data = '0;
    for (int c = 0; c < 600; c++) begin
      clear_start = ($urandom_range(0, 59) == 0);
      wr_req  = 1'($urandom_range(0, 1));
      rd_req  = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom);
      wr_data = 4'($urandom);
      rd_addr = 5'($urandom);
      {e_wg, e_rg, e_busy, e_wren, e_addr, e_data} = '0;
      n_valid = 1'b0; n_data = '0;
      if (clear_left > 0) begin
        e_busy = 1'b1; e_wren = 1'b1; e_addr = 5'(32 - clear_left);
        clear_left--;
      end else if (clear_start) begin
        clear_left = 32;
      end else if (wr_req && (!rd_req || !last_was_write)) begin
        e_wg = 1'b1; e_wren = 1'b1; e_addr = wr_addr; e_data = wr_data;
        last_was_write = 1'b1;
      end else if (rd_req) begin
        e_rg = 1'b1; e_addr = rd_addr;
        n_valid = 1'b1; n_data = ref_mem[rd_addr];
        last_was_write = 1'b0;
      end
      @(negedge clk);
      checks++; if ({wr_gnt, rd_gnt, busy, ram_wren, ram_addr, ram_data} !== {e_wg, e_rg, e_busy, e_wren, e_addr, e_data})
        begin errors++; $display("FAIL rand_port[%0d]: got wg=%b rg=%b busy=%b wren=%b addr=%0d data=%0h expected %b %b %b %b %0d %0h",
          c, wr_gnt, rd_gnt, busy, ram_wren, ram_addr, ram_data, e_wg, e_rg, e_busy, e_wren, e_addr, e_data); end
      checks++; if (rd_valid !== pend_valid || (pend_valid && rd_data !== pend_data))
        begin errors++; $display("FAIL rand_read[%0d]: got valid=%b data=%0h expected %b %0h", c, rd_valid, rd_data, pend_valid, pend_data); end
      if (e_wren) ref_mem[e_addr] = e_data;
      pend_valid = n_valid; pend_data = n_data;
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_contention();
    test_clear();
    test_stall();
    test_reset_mid_clear();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
